// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_add_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/serial_add_cell.sv
// One-bit Mealy full-adder stage: combinational sum/carry, registered carry.
module serial_add_cell (
   input  logic clk,
   input  logic reset,
   input  logic a,
   input  logic b,
   input  logic load,
   input  logic load_c,
   output logic sum,
   output logic carry_next,
   output logic carry
);

   logic carry_q;

   assign sum        = a ^ b ^ carry_q;
   assign carry_next = (a & b) | (a & carry_q) | (b & carry_q);
   assign carry      = carry_q;

   // Outside SHIFT the operands are zero-filled, so free-running just drains carry to 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         carry_q <= 1'b0;
      end else if (load) begin
         carry_q <= load_c;
      end else begin
         carry_q <= carry_next;
      end
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer that feeds parallel operands LSB-first through serial_add_cell.
//  state    | meaning
//  ST_IDLE  | ready for start, result/cout/overflow hold last values
//  ST_SHIFT | one sum bit per clock, WIDTH clocks
//  ST_DONE  | one-cycle done pulse, then back to IDLE
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int CNT_W = $clog2(WIDTH);

   state_e             state_q;
   logic [WIDTH-1:0]   sh_a_q, sh_b_q, result_q;
   logic [WIDTH-1:0]   sh_a_d, sh_b_d, result_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               cout_q, ovf_q;
   logic               ready_q, busy_q, done_q;
   logic               accept, last_bit;
   logic               sum, carry_next, carry;

   assign accept   = (state_q == ST_IDLE) && start;
   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
   assign sh_a_d   = {1'b0, sh_a_q[WIDTH-1:1]};
   assign sh_b_d   = {1'b0, sh_b_q[WIDTH-1:1]};
   assign result_d = {sum, result_q[WIDTH-1:1]};

   serial_add_cell u_cell (
      .clk        (clk),
      .reset      (reset),
      .a          (sh_a_q[0]),
      .b          (sh_b_q[0]),
      .load       (accept),
      .load_c     (cin),
      .sum        (sum),
      .carry_next (carry_next),
      .carry      (carry)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         sh_a_q   <= '0;
         sh_b_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  sh_a_q  <= op_a;
                  sh_b_q  <= op_b;
                  cnt_q   <= '0;
                  state_q <= ST_SHIFT;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            ST_SHIFT: begin
               sh_a_q   <= sh_a_d;
               sh_b_q   <= sh_b_d;
               result_q <= result_d;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (last_bit) begin
                  cout_q  <= carry_next;
                  ovf_q   <= carry ^ carry_next;
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready    = ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with hand-computed sums.
module tb_serial_add_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] op_a = '0;
   logic [WIDTH-1:0] op_b = '0;
   logic             cin = 1'b0;
   logic             ready, busy, done, cout, overflow;
   logic [WIDTH-1:0] result;

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op_a     (op_a),
      .op_b     (op_b),
      .cin      (cin),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Edges after the accepting edge until done is seen (WIDTH expected).
   task automatic wait_done(input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (done !== 1'b1 && n < 20);
      chk({tag, "_lat"}, n, WIDTH);
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic [7:0] exp_r, input logic exp_co,
                         input logic exp_ov);
      @(negedge clk);
      op_a = a; op_b = b; cin = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_busy"}, busy, 1);
      wait_done(tag);
      chk({tag, "_res"}, result, exp_r);
      chk({tag, "_cout"}, cout, exp_co);
      chk({tag, "_ovf"}, overflow, exp_ov);
      @(posedge clk); #1;
      chk({tag, "_rdy"}, ready, 1);
      chk({tag, "_done_low"}, done, 0);
   endtask

   initial begin
      int base;
      #12;
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", overflow, 0);
      @(negedge clk);
      reset = 1'b0;

      // idle with start low
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("idle_ready", ready, 1);
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
         chk("idle_result", result, 0);
      end

      run_op("t1", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
      run_op("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op("t3a", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
      run_op("t3b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

      // start held high, operands change mid-flight
      base = done_cnt;
      @(negedge clk);
      op_a = 8'h12; op_b = 8'h34; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      op_a = 8'hAA; op_b = 8'h55;
      wait_done("t4a");
      chk("t4a_res", result, 8'h46);
      @(posedge clk); #1;
      chk("t4_rdy", ready, 1);
      @(posedge clk); #1;
      chk("t4_reaccept", busy, 1);
      start = 1'b0;
      wait_done("t4b");
      chk("t4b_res", result, 8'hFF);
      chk("t4b_cout", cout, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("t4_pulses", done_cnt - base, 2);

      // reset mid-operation
      base = done_cnt;
      @(negedge clk);
      op_a = 8'hF0; op_b = 8'h0F; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("t5_ready", ready, 1);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      chk("t5_result", result, 0);
      chk("t5_cout", cout, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("t5_no_done", done_cnt - base, 0);
      run_op("t5b", 8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
